// File: rtl/button_debounce_edge.sv
// ---------------------------------------------------------------------------
// button_debounce_edge
//   Conditions the raw board push-button for the Gray counter. The pin is
//   synchronised into the clk domain. A level change is accepted only after
//   DEBOUNCE_CYCLES consecutive stable samples. Accepted changes produce a
//   clean level plus registered one-cycle press/release strobes.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   button_in      in   raw button pin, asynchronous to clk
//   button_state   out  debounced level, 1 = pressed
//   button_posedge out  one-cycle strobe on accepted press
//   button_negedge out  one-cycle strobe on accepted release
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (1 .. 2^CNT_W)
//   CNT_W            stability counter width
//   SYNC_STAGES      synchroniser depth, minimum 2
//   ACTIVE_LOW       1 = pin reads 0 when pressed
// ---------------------------------------------------------------------------
module button_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic button_state,
    output logic button_posedge,
    output logic button_negedge
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    logic                   w_b;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_pos;
    logic                   r_neg;
    logic                   w_pos_nxt;
    logic                   w_neg_nxt;

    // Normalise polarity so that 1 always means pressed downstream.
    assign w_b = button_in ^ (ACTIVE_LOW != 0);

    // Synchroniser chain. It resets to 0 (released) so that a button held
    // through reset is seen as a fresh press once reset lifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_b};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // State, counter and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    // Next-state logic. The counter runs only in the ARM_* states. Any sample
    // back at the old level returns the FSM to the stable state, so the next
    // attempt restarts from 0. The counter stops at CNT_LAST and never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = 1'b0;
        w_neg_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_state_nxt = ARM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_PRESS: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_pos_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = ARM_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_RELEASE: begin
                if (w_sync) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_neg_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The level is decoded from the registered state. It therefore changes on
    // the same edge that raises the matching strobe.
    assign button_state   = (r_state == PRESSED) || (r_state == ARM_RELEASE);
    assign button_posedge = r_pos;
    assign button_negedge = r_neg;

endmodule

// File: tb/tb_button_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_button_debounce_edge
//   Directed bench for button_debounce_edge with DEBOUNCE_CYCLES=4 and
//   SYNC_STAGES=2. Two instances run side by side. One is active-high. The
//   other is active-low and gets the inverted pin, so both must show the same
//   outputs. Edge k is the k-th rising edge after the stimulus is applied.
//   Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_button_debounce_edge;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic btn_n;
    logic st0, pe0, ne0;
    logic st1, pe1, ne1;
    logic [2:0] o0, o1;

    int n_cmp = 0;
    int n_err = 0;

    assign btn_n = ~btn;
    assign o0 = {st0, pe0, ne0};
    assign o1 = {st1, pe1, ne1};

    always #5 clk = ~clk;

    button_debounce_edge #(
        .DEBOUNCE_CYCLES(4), .CNT_W(4), .SYNC_STAGES(2), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .button_in(btn),
        .button_state(st0), .button_posedge(pe0), .button_negedge(ne0)
    );

    button_debounce_edge #(
        .DEBOUNCE_CYCLES(4), .CNT_W(4), .SYNC_STAGES(2), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .button_in(btn_n),
        .button_state(st1), .button_posedge(pe1), .button_negedge(ne1)
    );

    // Bring both instances to IDLE with the button released. The task ends
    // 1 ns after a rising edge.
    task automatic go_reset();
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        go_reset();
        btn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if ({o0, o1} !== 6'b100_100) begin
            n_err++;
            $display("FAIL reset_pre_state got=%b/%b exp=100", o0, o1);
        end
        // Assert reset mid-cycle. The outputs must clear before the next edge.
        #3 rst = 1'b1;
        btn = 1'b0;
        #1;
        n_cmp++;
        if ({o0, o1} !== 6'b000_000) begin
            n_err++;
            $display("FAIL reset_async got=%b/%b exp=000", o0, o1);
        end
        for (int i = 0; i < 4; i++) begin
            #2 btn = ~btn;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o0, o1} !== 6'b000_000) begin
                n_err++;
                $display("FAIL reset_held i=%0d got=%b/%b exp=000", i, o0, o1);
            end
        end
        btn = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o0, o1} !== 6'b000_000) begin
                n_err++;
                $display("FAIL reset_after i=%0d got=%b/%b exp=000", i, o0, o1);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        go_reset();
        for (int k = 1; k <= 10; k++) begin
            btn = 1'b1;
            @(posedge clk);
            #1;
            exp = {k >= 7, k == 7, 1'b0};
            n_cmp++;
            if ({o0, o1} !== {exp, exp}) begin
                n_err++;
                $display("FAIL clean_press k=%0d got=%b/%b exp=%b", k, o0, o1, exp);
            end
        end
    endtask

    task automatic test_glitch();
        go_reset();
        for (int k = 1; k <= 12; k++) begin
            btn = (k <= 4);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o0, o1} !== 6'b000_000) begin
                n_err++;
                $display("FAIL glitch k=%0d got=%b/%b exp=000", k, o0, o1);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp;
        go_reset();
        for (int k = 1; k <= 15; k++) begin
            btn = (k != 4);
            @(posedge clk);
            #1;
            exp = {k >= 11, k == 11, 1'b0};
            n_cmp++;
            if ({o0, o1} !== {exp, exp}) begin
                n_err++;
                $display("FAIL bounce k=%0d got=%b/%b exp=%b", k, o0, o1, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] exp;
        go_reset();
        btn = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        for (int k = 1; k <= 10; k++) begin
            btn = 1'b0;
            @(posedge clk);
            #1;
            exp = {k < 7, 1'b0, k == 7};
            n_cmp++;
            if ({o0, o1} !== {exp, exp}) begin
                n_err++;
                $display("FAIL release k=%0d got=%b/%b exp=%b", k, o0, o1, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        int npos;
        go_reset();
        // After edge 5 the FSM is in ARM_PRESS with counter = 2.
        for (int k = 1; k <= 5; k++) begin
            btn = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o0, o1} !== 6'b000_000) begin
                n_err++;
                $display("FAIL mid_arm k=%0d got=%b/%b exp=000", k, o0, o1);
            end
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o0, o1} !== 6'b000_000) begin
            n_err++;
            $display("FAIL mid_rst_async got=%b/%b exp=000", o0, o1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({o0, o1} !== 6'b000_000) begin
                n_err++;
                $display("FAIL mid_rst_held i=%0d got=%b/%b exp=000", i, o0, o1);
            end
        end
        rst = 1'b0;
        npos = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (pe0 === 1'b1) npos++;
            exp = {k >= 7, k == 7, 1'b0};
            n_cmp++;
            if ({o0, o1} !== {exp, exp}) begin
                n_err++;
                $display("FAIL mid_post k=%0d got=%b/%b exp=%b", k, o0, o1, exp);
            end
        end
        n_cmp++;
        if (npos !== 1) begin
            n_err++;
            $display("FAIL mid_posedge_count got=%0d exp=1", npos);
        end
    endtask

    // Press, then release as soon as the press is accepted.
    task automatic test_back_to_back();
        logic [2:0] exp;
        go_reset();
        for (int k = 1; k <= 16; k++) begin
            btn = (k <= 7);
            @(posedge clk);
            #1;
            exp = {(k >= 7) && (k < 14), k == 7, k == 14};
            n_cmp++;
            if ({o0, o1} !== {exp, exp}) begin
                n_err++;
                $display("FAIL back_to_back k=%0d got=%b/%b exp=%b", k, o0, o1, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        #1;
        n_cmp++;
        if ({o0, o1} !== 6'b000_000) begin
            n_err++;
            $display("FAIL reset_initial got=%b/%b exp=000", o0, o1);
        end
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
